// File: rtl/gameman_fb_pkg.sv
// Shared constants and types for the framebuffer write path.
// Build option: FBW_DOUBLE_BUF_EN selects a two-bank framebuffer (16-bit address).
package gameman_fb_pkg;

  localparam int FB_WIDTH  = 160;
  localparam int FB_HEIGHT = 144;
  localparam int FB_PIXELS = FB_WIDTH * FB_HEIGHT;

`ifdef FBW_DOUBLE_BUF_EN
  localparam int ADDR_W = 16;
`else
  localparam int ADDR_W = 15;
`endif

  localparam int X_W = 8;
  localparam int Y_W = 8;

  typedef logic [1:0] pixel_t;

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    ACTIVE     = 2'd1,
    FRAME_END  = 2'd2
  } fbw_state_t;

endpackage

// File: rtl/fb_addr_counter.sv
// x/y position and running line base address for the framebuffer writer.
// The line base is advanced by FB_WIDTH per line so no multiplier is needed.
// A clear together with a pixel step leaves x at 1: the pixel became (0,0).
// A line step together with a pixel step leaves x at 0: the pixel closed the line.
module fb_addr_counter
  import gameman_fb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              pixel_step,
  input  logic              line_step,
  output logic [X_W-1:0]    x,
  output logic [Y_W-1:0]    y,
  output logic [ADDR_W-1:0] line_base
);

  // Position counters: clear wins, then line step, then pixel step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x         <= '0;
      y         <= '0;
      line_base <= '0;
    end else if (clear) begin
      x         <= pixel_step ? X_W'(1) : X_W'(0);
      y         <= '0;
      line_base <= '0;
    end else if (line_step) begin
      x         <= '0;
      y         <= y + Y_W'(1);
      line_base <= line_base + ADDR_W'(FB_WIDTH);
    end else if (pixel_step) begin
      x         <= x + X_W'(1);
    end
  end

endmodule

// File: rtl/fb_pixel_writer.sv
// PPU pixel stream to framebuffer BRAM port A writer.
// Writes land one cycle after the accepted pixel; there is no backpressure.
// Build option: FBW_DOUBLE_BUF_EN adds a write bank in addra[15] that flips
// at frame completion, with disp_bank pointing at the finished bank.
module fb_pixel_writer
  import gameman_fb_pkg::*;
(
  input  logic              clk_100mhz,
  input  logic              rst,
  input  logic              ppu_vsync,
  input  logic              ppu_hsync,
  input  logic              px_valid,
  input  logic [1:0]        px_data,
  output logic              clka,
  output logic [ADDR_W-1:0] addra,
  output logic [1:0]        dina,
  output logic              wea,
  output logic              frame_done,
  output logic              err_overrun,
  output logic              err_short,
  output logic              disp_bank
);

  fbw_state_t state, state_next;

  logic [X_W-1:0]    x;
  logic [Y_W-1:0]    y;
  logic [ADDR_W-1:0] line_base;
  logic [ADDR_W-1:0] lin_addr;
  logic [ADDR_W-1:0] write_addr;
  logic [X_W-1:0]    x_after;
  logic              clear;
  logic              pixel_step;
  logic              line_step;
  logic              write_en;
  logic              drop;
  logic              short_line;
  logic              frame_end;
  logic              wbank;

  assign clka = clk_100mhz;

  fb_addr_counter u_cnt (
    .clk        (clk_100mhz),
    .rst        (rst),
    .clear      (clear),
    .pixel_step (pixel_step),
    .line_step  (line_step),
    .x          (x),
    .y          (y),
    .line_base  (line_base)
  );

  // FSM state register.
  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      state <= WAIT_FRAME;
    end else begin
      state <= state_next;
    end
  end

  // Next state and per-cycle write/error decisions; vsync overrides everything.
  always_comb begin
    state_next = state;
    clear      = 1'b0;
    pixel_step = 1'b0;
    line_step  = 1'b0;
    write_en   = 1'b0;
    drop       = 1'b0;
    short_line = 1'b0;
    frame_end  = 1'b0;
    x_after    = x;
    if (ppu_vsync) begin
      state_next = ACTIVE;
      clear      = 1'b1;
      if (px_valid) begin
        pixel_step = 1'b1;
        write_en   = 1'b1;
      end else begin
        pixel_step = 1'b0;
      end
    end else begin
      case (state)
        ACTIVE: begin
          if (px_valid) begin
            if (x < X_W'(FB_WIDTH)) begin
              pixel_step = 1'b1;
              write_en   = 1'b1;
              x_after    = x + X_W'(1);
            end else begin
              drop = 1'b1;
            end
          end else begin
            x_after = x;
          end
          if (ppu_hsync) begin
            line_step  = 1'b1;
            short_line = (x_after != X_W'(FB_WIDTH));
            if (y == Y_W'(FB_HEIGHT - 1)) begin
              frame_end  = 1'b1;
              state_next = FRAME_END;
            end else begin
              state_next = ACTIVE;
            end
          end else begin
            state_next = ACTIVE;
          end
        end
        WAIT_FRAME, FRAME_END: begin
          drop = px_valid;
        end
        default: begin
          state_next = WAIT_FRAME;
          drop       = px_valid;
        end
      endcase
    end
  end

  assign lin_addr = clear ? '0 : (line_base + ADDR_W'(x));

`ifdef FBW_DOUBLE_BUF_EN
  assign write_addr = {wbank, lin_addr[ADDR_W-2:0]};

  // Write bank flips as frame_done rises; the reader shows the other bank.
  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      wbank     <= 1'b0;
      disp_bank <= 1'b1;
    end else if (frame_end) begin
      wbank     <= ~wbank;
      disp_bank <= wbank;
    end
  end
`else
  assign wbank      = 1'b0;
  assign write_addr = lin_addr | {ADDR_W{wbank}};
  assign disp_bank  = 1'b0;
`endif

  // Registered BRAM port A signals, frame pulse and sticky error flags.
  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      addra       <= '0;
      dina        <= 2'd0;
      wea         <= 1'b0;
      frame_done  <= 1'b0;
      err_overrun <= 1'b0;
      err_short   <= 1'b0;
    end else begin
      wea        <= write_en;
      frame_done <= frame_end;
      if (write_en) begin
        addra <= write_addr;
        dina  <= px_data;
      end
      if (drop) begin
        err_overrun <= 1'b1;
      end
      if (short_line) begin
        err_short <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Self-checking bench for fb_pixel_writer: directed table, hand sequences
// for line/frame corner cases and reset, then randomized full frames
// checked cycle by cycle against a behavioural model.
module tb_fb_pixel_writer;
  import gameman_fb_pkg::*;

  logic              clk_100mhz = 1'b0;
  logic              rst = 1'b1;
  logic              ppu_vsync = 1'b0;
  logic              ppu_hsync = 1'b0;
  logic              px_valid = 1'b0;
  logic [1:0]        px_data = 2'd0;
  logic              clka;
  logic [ADDR_W-1:0] addra;
  logic [1:0]        dina;
  logic              wea;
  logic              frame_done;
  logic              err_overrun;
  logic              err_short;
  logic              disp_bank;

  fb_pixel_writer dut (
    .clk_100mhz  (clk_100mhz),
    .rst         (rst),
    .ppu_vsync   (ppu_vsync),
    .ppu_hsync   (ppu_hsync),
    .px_valid    (px_valid),
    .px_data     (px_data),
    .clka        (clka),
    .addra       (addra),
    .dina        (dina),
    .wea         (wea),
    .frame_done  (frame_done),
    .err_overrun (err_overrun),
    .err_short   (err_short),
    .disp_bank   (disp_bank)
  );

  always #5 clk_100mhz = ~clk_100mhz;

`ifdef FBW_DOUBLE_BUF_EN
  localparam int NFRAMES = 2;
  localparam bit DB = 1'b1;
`else
  localparam int NFRAMES = 1;
  localparam bit DB = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  // behavioural model state: mode 0=waiting for frame, 1=drawing, 2=frame complete
  int m_mode, m_x, m_y, m_wbank;
  bit m_ov, m_sh;
  bit e_wea, e_fd;
  int e_addr, e_din;

  int last_addr;
  int fd_count;

  typedef struct {
    bit vs, hs, v;
    logic [1:0] d;
    bit wea;
    int addr;
    int din;
    bit ov, sh;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_x = 0; m_y = 0; m_wbank = 0;
    m_ov = 0; m_sh = 0; e_wea = 0; e_fd = 0; e_addr = 0; e_din = 0;
  endtask

  task automatic model(input bit vs, input bit hs, input bit v, input logic [1:0] d);
    e_wea = 0;
    e_fd = 0;
    if (vs) begin
      m_mode = 1; m_x = 0; m_y = 0;
      if (v) begin
        e_wea = 1; e_addr = m_wbank * 32768; e_din = d; m_x = 1;
      end
    end else begin
      if (v) begin
        if (m_mode == 1 && m_x < FB_WIDTH) begin
          e_wea = 1; e_addr = m_wbank * 32768 + FB_WIDTH * m_y + m_x; e_din = d;
          m_x++;
        end else begin
          m_ov = 1;
        end
      end
      if (hs && m_mode == 1) begin
        if (m_x != FB_WIDTH) m_sh = 1;
        m_x = 0;
        m_y++;
        if (m_y == FB_HEIGHT) begin
          e_fd = 1; m_mode = 2;
          if (DB) m_wbank = 1 - m_wbank;
        end
      end
    end
  endtask

  task automatic drive(input bit vs, input bit hs, input bit v, input logic [1:0] d);
    ppu_vsync = vs; ppu_hsync = hs; px_valid = v; px_data = d;
    @(posedge clk_100mhz);
    #1;
    if (wea === 1'b1) last_addr = int'(addra);
    if (frame_done === 1'b1) fd_count++;
  endtask

  task automatic run(input bit vs, input bit hs, input bit v, input logic [1:0] d);
    model(vs, hs, v, d);
    drive(vs, hs, v, d);
    chk("wea", wea, e_wea);
    if (e_wea) begin
      chk("addra", addra, e_addr);
      chk("dina", dina, e_din);
    end
    chk("frame_done", frame_done, e_fd);
    chk("err_overrun", err_overrun, m_ov);
    chk("err_short", err_short, m_sh);
    chk("disp_bank", disp_bank, DB ? (1 - m_wbank) : 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ppu_vsync = 0; ppu_hsync = 0; px_valid = 0; px_data = 0;
    @(posedge clk_100mhz);
    #1;
    chk("rst_wea", wea, 0);
    chk("rst_addra", addra, 0);
    chk("rst_dina", dina, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_err_overrun", err_overrun, 0);
    chk("rst_err_short", err_short, 0);
    chk("rst_disp_bank", disp_bank, DB ? 1 : 0);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [1:0] d;
    int cnt;
    bit merged;

    // vs hs v d | wea addr din ov sh
    tbl[0]  = '{0, 0, 0, 2'd0, 0, 0,   0, 0, 0};
    tbl[1]  = '{0, 1, 0, 2'd0, 0, 0,   0, 0, 0};
    tbl[2]  = '{1, 0, 1, 2'd3, 1, 0,   3, 0, 0};
    tbl[3]  = '{0, 0, 1, 2'd1, 1, 1,   1, 0, 0};
    tbl[4]  = '{0, 0, 0, 2'd0, 0, 0,   0, 0, 0};
    tbl[5]  = '{0, 0, 1, 2'd2, 1, 2,   2, 0, 0};
    tbl[6]  = '{0, 1, 1, 2'd0, 1, 3,   0, 0, 1};
    tbl[7]  = '{0, 0, 1, 2'd1, 1, 160, 1, 0, 1};
    tbl[8]  = '{1, 1, 1, 2'd2, 1, 0,   2, 0, 1};
    tbl[9]  = '{0, 0, 1, 2'd3, 1, 1,   3, 0, 1};
    tbl[10] = '{0, 1, 0, 2'd0, 0, 0,   0, 0, 1};
    tbl[11] = '{0, 0, 1, 2'd0, 1, 160, 0, 0, 1};

    #3;
    do_reset();

    // directed table
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].vs, tbl[i].hs, tbl[i].v, tbl[i].d);
      chk($sformatf("tbl%0d_wea", i), wea, tbl[i].wea);
      if (tbl[i].wea) begin
        chk($sformatf("tbl%0d_addra", i), addra, tbl[i].addr);
        chk($sformatf("tbl%0d_dina", i), dina, tbl[i].din);
      end
      chk($sformatf("tbl%0d_ovr", i), err_overrun, tbl[i].ov);
      chk($sformatf("tbl%0d_short", i), err_short, tbl[i].sh);
    end

    // overlong line, short line, pixel coincident with hsync, vsync mid-frame
    do_reset();
    run(1, 0, 0, 2'd0);
    for (int i = 0; i < 161; i++) run(0, 0, 1, 2'(i % 4));
    chk("overrun_161", err_overrun, 1);
    chk("overrun_last_addr", last_addr, 159);
    run(0, 1, 0, 2'd0);
    chk("full_line_no_short", err_short, 0);
    for (int i = 0; i < 100; i++) run(0, 0, 1, 2'(i % 4));
    run(0, 1, 0, 2'd0);
    chk("short_line", err_short, 1);
    run(0, 0, 1, 2'd2);
    chk("line2_base", addra, 320);
    for (int i = 1; i < 159; i++) run(0, 0, 1, 2'(i % 4));
    run(0, 1, 1, 2'd3);
    chk("px_hsync_addr", addra, 479);
    run(0, 0, 1, 2'd1);
    chk("after_px_hsync", addra, 480);
    run(1, 0, 1, 2'd2);
    chk("px_vsync_addr", addra, 0);
    chk("px_vsync_wea", wea, 1);

    // reset mid-line at x=50
    do_reset();
    run(1, 0, 0, 2'd0);
    for (int i = 0; i < 50; i++) run(0, 0, 1, 2'(i % 4));
    chk("pre_rst_wea", wea, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_wea", wea, 0);
    chk("async_rst_addra", addra, 0);
    #1 rst = 1'b0;
    model_reset();
    run(0, 0, 1, 2'd1);
    chk("post_rst_drop", err_overrun, 1);
    run(0, 1, 0, 2'd0);
    run(0, 0, 1, 2'd2);

    // randomized full frames against the model
    do_reset();
    fd_count = 0;
    for (int f = 0; f < NFRAMES; f++) begin
      run(1, 0, 0, 2'd0);
      for (int ln = 0; ln < FB_HEIGHT; ln++) begin
        cnt = 0;
        merged = 0;
        while (cnt < FB_WIDTH) begin
          if ($urandom_range(0, 3) == 0) begin
            run(0, 0, 0, 2'd0);
          end else begin
            d = 2'($urandom);
            if (cnt == FB_WIDTH - 1 && $urandom_range(0, 1) == 1) begin
              run(0, 1, 1, d);
              merged = 1;
            end else begin
              run(0, 0, 1, d);
            end
            cnt++;
          end
        end
        if (!merged) run(0, 1, 0, 2'd0);
      end
      run(0, 0, 0, 2'd0);
      chk("frame_last_addr", last_addr % 32768, FB_PIXELS - 1);
      chk("frame_done_count", fd_count, f + 1);
      chk("frame_no_errors", {err_overrun, err_short}, 0);
      if (DB) begin
        chk("frame_bank", last_addr / 32768, f % 2);
        chk("disp_after_frame", disp_bank, (f % 2 == 0) ? 0 : 1);
      end
    end
    run(0, 1, 0, 2'd0);
    run(0, 0, 1, 2'd0);
    chk("frame_end_drop", err_overrun, 1);
    chk("frame_end_no_write", wea, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
